// File: rtl/mode_seq_ctrl.sv
// Mode sequencing controller: accepts mode-change requests, validates them
// against lock/legality rules, settles, then commits the new mode.
module mode_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  input  logic       lock,
  input  logic       err_clr,
  output logic [2:0] mode,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] trans_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SETTLE = 3'd2,
    ERROR  = 3'd3
  } state_t;

  // Kept as a plain vector so unused encodings stay reachable and recoverable.
  logic [2:0] state_q;
  state_t     state_d;
  logic [2:0] target_q, target_d;
  logic [2:0] mode_q, mode_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [7:0] trans_q, trans_d;

  logic step_up, step_down, legal;

  assign step_up   = ({1'b0, target_q} == ({1'b0, mode_q} + 4'd1));
  assign step_down = (mode_q != 3'd0) && (target_q == (mode_q - 3'd1));
  assign legal     = (target_q == 3'd0) || step_up || step_down;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= 3'd0;
      mode_q   <= 3'd0;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      trans_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      code_q   <= code_d;
      trans_q  <= trans_d;
    end
  end

  always_comb begin
    state_d  = state_t'(state_q);
    target_d = target_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    code_d   = code_q;
    trans_d  = trans_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_mode;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // Priority: reserved mode, then lock, then no-op, then legality.
        if (target_q == 3'd7) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end else if (lock && (target_q != 3'd0)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd3;
        end else if (target_q == mode_q) begin
          state_d = IDLE;
        end else if (legal) begin
          state_d = SETTLE;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          mode_d  = target_q;
          trans_d = trans_q + 8'd1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ERROR: begin
        if (err_clr) begin
          state_d = IDLE;
          err_d   = 1'b0;
          code_d  = 2'd0;
        end
      end
      default: begin
        state_d = ERROR;
        mode_d  = 3'd0;
        err_d   = 1'b1;
        code_d  = 2'd1;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE) && rst_n;
  assign busy      = (state_q != IDLE);
  assign mode      = mode_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign trans_cnt = trans_q;

endmodule

// File: tb/tb_mode_seq_ctrl.sv
// Randomized + directed bench for mode_seq_ctrl, checked against a
// cycle-level reference model built from the controller's rules.
module tb_mode_seq_ctrl;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, lock, err_clr;
  logic [2:0] req_mode;
  logic       req_ready, busy, err;
  logic [2:0] mode;
  logic [1:0] err_code;
  logic [7:0] trans_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic cur_lock = 1'b0;

  // Reference model: outstanding-work flags plus an edges-to-commit countdown.
  bit m_in_error, m_check_pending;
  int m_commit_in, m_target, m_mode, m_err, m_code, m_cnt;

  mode_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .lock(lock), .err_clr(err_clr), .mode(mode),
    .busy(busy), .err(err), .err_code(err_code), .trans_cnt(trans_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit modelIdle();
    return !m_in_error && !m_check_pending && (m_commit_in == 0);
  endfunction

  function automatic void raiseErr(input int code);
    m_in_error = 1'b1;
    m_err      = 1;
    m_code     = code;
  endfunction

  task automatic modelStep();
    if (!rst_n) begin
      m_in_error = 0; m_check_pending = 0; m_commit_in = 0;
      m_target = 0; m_mode = 0; m_err = 0; m_code = 0; m_cnt = 0;
    end else if (m_in_error) begin
      if (err_clr) begin
        m_in_error = 0; m_err = 0; m_code = 0;
      end
    end else if (m_check_pending) begin
      m_check_pending = 0;
      if (m_target == 7) raiseErr(2);
      else if (lock && m_target != 0) raiseErr(3);
      else if (m_target == m_mode) begin end
      else if (m_target == 0 || m_target == m_mode + 1 || m_target == m_mode - 1)
        m_commit_in = SETTLE;
      else raiseErr(1);
    end else if (m_commit_in > 0) begin
      m_commit_in--;
      if (m_commit_in == 0) begin
        m_mode = m_target;
        m_cnt  = (m_cnt + 1) % 256;
      end
    end else if (req_valid) begin
      m_check_pending = 1;
      m_target        = int'(req_mode);
    end
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("mode", int'(mode), m_mode);
    checkOutput("busy", int'(busy), modelIdle() ? 0 : 1);
    checkOutput("err", int'(err), m_err);
    checkOutput("err_code", int'(err_code), m_code);
    checkOutput("trans_cnt", int'(trans_cnt), m_cnt);
    checkOutput("req_ready", int'(req_ready), (modelIdle() && rst_n) ? 1 : 0);
  endtask

  // Drive one cycle of inputs from a negedge, advance the model on the edge,
  // then compare everything on the following negedge.
  task automatic applyStimulus(input logic v, input logic [2:0] m, input logic l,
                               input logic c, input logic r);
    req_valid = v; req_mode = m; lock = l; err_clr = c; rst_n = r;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 3'd0, cur_lock, 1'b0, 1'b1);
  endtask

  task automatic request(input int t);
    applyStimulus(1'b1, 3'(t), cur_lock, 1'b0, 1'b1);
  endtask

  task automatic clearErr();
    applyStimulus(1'b0, 3'd0, cur_lock, 1'b1, 1'b1);
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      idleCycle();
    end
    checkOutput("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int edges, busy_cycles;
    req_valid = 0; req_mode = 0; lock = 0; err_clr = 0; rst_n = 0;
    m_in_error = 0; m_check_pending = 0; m_commit_in = 0;
    m_target = 0; m_mode = 0; m_err = 0; m_code = 0; m_cnt = 0;
    @(negedge clk);

    // Reset, then 0 -> 1 with latency and busy-length measurement
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_ready", int'(req_ready), 0);
    checkOutput("reset_mode", int'(mode), 0);
    request(1);
    edges = 0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      idleCycle();
      edges++;
      if (busy) busy_cycles++;
      if (mode == 3'd1) break;
    end
    checkOutput("commit_latency", edges, SETTLE + 1);
    checkOutput("busy_cycles", busy_cycles, SETTLE + 1);
    checkOutput("first_trans_cnt", int'(trans_cnt), 1);

    // Illegal transition 1 -> 3, then clear
    request(3);
    idleCycle();
    checkOutput("illegal_err", int'(err), 1);
    checkOutput("illegal_code", int'(err_code), 1);
    checkOutput("illegal_mode", int'(mode), 1);
    checkOutput("illegal_ready", int'(req_ready), 0);
    clearErr();
    checkOutput("clr_err", int'(err), 0);
    checkOutput("clr_code", int'(err_code), 0);
    checkOutput("clr_ready", int'(req_ready), 1);

    // Reserved mode beats lock
    cur_lock = 1'b1;
    request(7);
    idleCycle();
    checkOutput("reserved_code", int'(err_code), 2);
    clearErr();
    cur_lock = 1'b0;

    // Lock behaviour from mode 2
    request(2);
    waitIdle(20);
    checkOutput("mode2", int'(mode), 2);
    cur_lock = 1'b1;
    request(3);
    idleCycle();
    checkOutput("locked_code", int'(err_code), 3);
    checkOutput("locked_mode", int'(mode), 2);
    clearErr();
    request(0);
    waitIdle(20);
    checkOutput("locked_to0_mode", int'(mode), 0);
    checkOutput("locked_to0_cnt", int'(trans_cnt), 3);
    cur_lock = 1'b0;

    // Reset in the second SETTLE cycle aborts the commit
    request(1);
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_mode", int'(mode), 0);
    checkOutput("abort_cnt", int'(trans_cnt), 0);
    for (int i = 0; i < 8; i++) idleCycle();
    checkOutput("abort_no_commit_mode", int'(mode), 0);
    checkOutput("abort_no_commit_cnt", int'(trans_cnt), 0);

    // 256 alternating commits wrap the counter
    for (int k = 0; k < 256; k++) begin
      request((k % 2 == 0) ? 1 : 0);
      waitIdle(20);
      if (k == 254) checkOutput("cnt_255", int'(trans_cnt), 255);
    end
    checkOutput("cnt_wrap", int'(trans_cnt), 0);
    checkOutput("wrap_mode", int'(mode), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 39) != 0));
    end

    // Illegal state encoding recovery
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cur_lock = 1'b0;
    request(1);
    waitIdle(20);
    checkOutput("pre_force_mode", int'(mode), 1);
    force dut.state_q = 3'd5;
    #1 release dut.state_q;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bad_state_mode", int'(mode), 0);
    checkOutput("bad_state_code", int'(err_code), 1);
    checkOutput("bad_state_err", int'(err), 1);
    checkOutput("bad_state_cnt", int'(trans_cnt), 1);
    m_in_error = 1; m_err = 1; m_code = 1; m_mode = 0;
    clearErr();
    checkOutput("bad_state_recover", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
